frame_dump_ctrl: RTL

FRAME_DUMP_CTRL -- requirements
Module: frame_dump_ctrl

---
 rtl/frame_dump_ctrl_pkg.sv | 25 ++
 rtl/frame_dump_ctrl_if.sv | 29 ++
 rtl/frame_dump_ctrl_btn_debounce.sv | 33 +++
 rtl/frame_dump_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/frame_dump_ctrl_pkg.sv
// Shared types and constants for the frame dump controller: FSM state
// encoding, default sync header bytes, address widths and the test pixel pattern.
package frame_dump_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR0  = 3'd1,
        ST_HDR1  = 3'd2,
        ST_FETCH = 3'd3,
        ST_SEND  = 3'd4,
        ST_DONE  = 3'd5
    } fdc_state_t;

    localparam logic [7:0] SYNC0_DEFAULT = 8'hA5;
    localparam logic [7:0] SYNC1_DEFAULT = 8'h5A;

    localparam int XW = 6;
    localparam int YW = 5;

    // Raster-index pattern used to fill a buffer with recognisable content.
    function automatic logic [7:0] pixel_pattern(input int x, input int y, input int w);
        return 8'((x + y * w) % 256);
    endfunction

endpackage

// File: rtl/frame_dump_ctrl_if.sv
// Buffer-read and UART-write bus between the dump controller (master) and
// its environment (slave), plus status and a debug view of the FSM state.
interface frame_dump_ctrl_if;
    import frame_dump_ctrl_pkg::*;

    logic [XW-1:0] read_x;
    logic [YW-1:0] read_y;
    logic [7:0]    read_q;
    logic          uart_busy;
    logic          uart_wr;
    logic [7:0]    uart_dat;
    logic          dump_active;
    logic          dump_done;
    fdc_state_t    dbg_state;

    // Handshake: uart_wr is a one-cycle strobe that only fires while uart_busy
    // is low and the holdoff gap has elapsed; uart_dat is stable from that
    // strobe until the next one. read_q answers read_x/read_y one cycle later.
    modport master (
        output read_x, read_y, uart_wr, uart_dat, dump_active, dump_done, dbg_state,
        input  read_q, uart_busy
    );

    modport slave (
        input  read_x, read_y, uart_wr, uart_dat, dump_active, dump_done, dbg_state,
        output read_q, uart_busy
    );

endinterface

// File: rtl/frame_dump_ctrl_btn_debounce.sv
// Button conditioner: one register stage plus a quiet-time counter; a press is
// reported on the first registered high after the button was low long enough.
module btn_debounce #(
    parameter int DEBOUNCE_BITS = 14
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_btn_reg,
    output logic o_pressed
);

    logic                     r_btn;
    logic [DEBOUNCE_BITS-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_btn <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_btn <= i_btn;
            if (r_btn) begin
                r_cnt <= '0;
            end else if (!(&r_cnt)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_btn_reg = r_btn;
    assign o_pressed = r_btn & (&r_cnt);

endmodule

// File: rtl/frame_dump_ctrl.sv
// Streams a sync header and then the whole downsample buffer in raster order
// to a UART, one byte per idle gap, after a debounced button press.
module frame_dump_ctrl
    import frame_dump_ctrl_pkg::*;
#(
    parameter int          WIDTH         = 40,
    parameter int          HEIGHT        = 30,
    parameter int          DEBOUNCE_BITS = 14,
    parameter int          HOLDOFF_BITS  = 13,
    parameter logic [7:0]  SYNC0         = SYNC0_DEFAULT,
    parameter logic [7:0]  SYNC1         = SYNC1_DEFAULT
) (
    input  logic              clk12,
    input  logic              areset,
    input  logic              btn,
    frame_dump_ctrl_if.master bus
);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    fdc_state_t              r_state;
    logic [XW-1:0]           r_x;
    logic [YW-1:0]           r_y;
    logic                    r_wr;
    logic [7:0]              r_dat;
    logic                    r_active;
    logic                    r_done;
    logic                    r_arm;
    logic [HOLDOFF_BITS-1:0] r_holdoff;

    logic w_btn_reg;
    logic w_pressed;
    logic w_trigger;
    logic w_issue;

    btn_debounce #(
        .DEBOUNCE_BITS(DEBOUNCE_BITS)
    ) u_debounce (
        .i_clk    (clk12),
        .i_rst    (areset),
        .i_btn    (btn),
        .o_btn_reg(w_btn_reg),
        .o_pressed(w_pressed)
    );

    // Enforces a minimum quiet gap on the UART line after it goes idle.
    always_ff @(posedge clk12 or posedge areset) begin
        if (areset) begin
            r_holdoff <= '0;
        end else if (bus.uart_busy) begin
            r_holdoff <= '0;
        end else if (!(&r_holdoff)) begin
            r_holdoff <= r_holdoff + 1'b1;
        end
    end

    assign w_trigger = (r_state == ST_IDLE) && w_pressed && r_arm;
    assign w_issue   = (&r_holdoff) && !bus.uart_busy && !r_wr;

    always_ff @(posedge clk12 or posedge areset) begin
        if (areset) begin
            r_state  <= ST_IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_wr     <= 1'b0;
            r_dat    <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_arm    <= 1'b1;
        end else begin
            r_wr   <= 1'b0;
            r_done <= 1'b0;
            if (w_trigger) begin
                r_arm <= 1'b0;
            end else if (!w_btn_reg) begin
                r_arm <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_state  <= ST_HDR0;
                        r_x      <= '0;
                        r_y      <= '0;
                        r_active <= 1'b1;
                    end
                end
                ST_HDR0: begin
                    if (w_issue) begin
                        r_wr    <= 1'b1;
                        r_dat   <= SYNC0;
                        r_state <= ST_HDR1;
                    end
                end
                ST_HDR1: begin
                    if (w_issue) begin
                        r_wr    <= 1'b1;
                        r_dat   <= SYNC1;
                        r_state <= ST_FETCH;
                    end
                end
                // Address was updated on entry; read_q is valid from next cycle.
                ST_FETCH: r_state <= ST_SEND;
                ST_SEND: begin
                    if (w_issue) begin
                        r_wr  <= 1'b1;
                        r_dat <= bus.read_q;
                        if (r_x == X_LAST && r_y == Y_LAST) begin
                            r_state  <= ST_DONE;
                            r_active <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            if (r_x == X_LAST) begin
                                r_x <= '0;
                                r_y <= r_y + 1'b1;
                            end else begin
                                r_x <= r_x + 1'b1;
                            end
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.read_x      = r_x;
    assign bus.read_y      = r_y;
    assign bus.uart_wr     = r_wr;
    assign bus.uart_dat    = r_dat;
    assign bus.dump_active = r_active;
    assign bus.dump_done   = r_done;
    assign bus.dbg_state   = r_state;

endmodule
